// File: rtl/btn_evt_pkg.sv
// Shared constants for the button press-event scheduler: event codes,
// FSM state encoding and a small parameter helper.
package btn_evt_pkg;

  localparam logic [1:0] EVT_SHORT  = 2'b00;
  localparam logic [1:0] EVT_LONG   = 2'b01;
  localparam logic [1:0] EVT_REPEAT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HELD   = 2'b01,
    ST_REPEAT = 2'b10
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_ctrl_press_timer.sv
// Hold-time counter: cleared or advanced by the FSM. The hit output flags
// the last cycle before the programmed limit is reached.
module press_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] cnt_r;

  // Hold counter: clear wins over enable; otherwise the count is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = (cnt_r == (limit - W'(1)));

endmodule

// File: rtl/btn_event_ctrl.sv
// Tracks one debounced button at a time, classifies the press as SHORT,
// LONG or auto-REPEAT and hands events out through a valid/ready register.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_BTN-1:0]         i_btn,
  input  logic                     i_evt_ready,
  input  logic                     i_ovf_clr,
  output logic                     o_evt_valid,
  output logic [$clog2(N_BTN)-1:0] o_evt_id,
  output logic [1:0]               o_evt_type,
  output logic                     o_busy,
  output logic                     o_overflow
);

  localparam int IW = $clog2(N_BTN);
  localparam int CW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYCLES);
  localparam logic          REP_EN   = (REPEAT_CYCLES != 0);

  logic [N_BTN-1:0] btn_q_r;
  logic [N_BTN-1:0] edge_s;
  logic [IW-1:0]    first_s;
  logic [IW-1:0]    sel_r;
  logic             held_s;
  state_e           state_r;
  state_e           state_nxt_s;
  logic             hit_s;
  logic             clear_s;
  logic             enable_s;
  logic [CW-1:0]    limit_s;
  logic             emit_s;
  logic [1:0]       emit_type_s;
  logic             evt_valid_r;
  logic [IW-1:0]    evt_id_r;
  logic [1:0]       evt_type_r;
  logic             busy_r;
  logic             ovf_r;
  logic             ovf_set_s;

  // Previous button levels; all ones so buttons held through reset need a fresh press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_q_r <= '1;
    end else begin
      btn_q_r <= i_btn;
    end
  end

  assign edge_s = i_btn & ~btn_q_r;
  assign held_s = i_btn[sel_r];

  // Lowest-index rising edge wins.
  always_comb begin
    first_s = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      first_s = edge_s[i] ? IW'(i) : first_s;
    end
  end

  // Latch the tracked button when a press starts from idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_r <= '0;
    end else if ((state_r == ST_IDLE) && (|edge_s)) begin
      sel_r <= first_s;
    end else begin
      sel_r <= sel_r;
    end
  end

  // FSM state register and registered busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state logic; release always beats the threshold.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|edge_s) begin
          state_nxt_s = ST_HELD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!held_s) begin
          state_nxt_s = ST_IDLE;
        end else if (hit_s) begin
          state_nxt_s = ST_REPEAT;
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      ST_REPEAT: begin
        if (!held_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REPEAT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: event emission and timer control.
  always_comb begin
    emit_s      = 1'b0;
    emit_type_s = EVT_SHORT;
    clear_s     = 1'b1;
    enable_s    = 1'b0;
    limit_s     = LONG_LIM;
    case (state_r)
      ST_IDLE: begin
        clear_s = 1'b1;
      end
      ST_HELD: begin
        limit_s = LONG_LIM;
        if (!held_s) begin
          emit_s      = 1'b1;
          emit_type_s = EVT_SHORT;
        end else if (hit_s) begin
          emit_s      = 1'b1;
          emit_type_s = EVT_LONG;
        end else begin
          clear_s  = 1'b0;
          enable_s = 1'b1;
        end
      end
      ST_REPEAT: begin
        limit_s = REP_LIM;
        if (!held_s) begin
          clear_s = 1'b1;
        end else if (REP_EN && hit_s) begin
          emit_s      = 1'b1;
          emit_type_s = EVT_REPEAT;
        end else begin
          clear_s  = 1'b0;
          enable_s = REP_EN;
        end
      end
      default: begin
        clear_s = 1'b1;
      end
    endcase
  end

  press_timer #(.W(CW)) u_timer (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (clear_s),
    .enable (enable_s),
    .limit  (limit_s),
    .hit    (hit_s)
  );

  // Event register: loads when free or being drained, otherwise holds its contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_valid_r <= 1'b0;
      evt_id_r    <= '0;
      evt_type_r  <= EVT_SHORT;
    end else if (emit_s && (!evt_valid_r || i_evt_ready)) begin
      evt_valid_r <= 1'b1;
      evt_id_r    <= sel_r;
      evt_type_r  <= emit_type_s;
    end else if (evt_valid_r && i_evt_ready) begin
      evt_valid_r <= 1'b0;
    end else begin
      evt_valid_r <= evt_valid_r;
    end
  end

  assign ovf_set_s = emit_s & evt_valid_r & ~i_evt_ready;

  // Sticky overflow; a new drop outranks a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (i_ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign o_evt_valid = evt_valid_r;
  assign o_evt_id    = evt_id_r;
  assign o_evt_type  = evt_type_r;
  assign o_busy      = busy_r;
  assign o_overflow  = ovf_r;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed press scenarios plus random button
// activity, compared every cycle with a press-age based reference model.
module tb_btn_event_ctrl;

  localparam int N  = 5;
  localparam int L  = 8;
  localparam int R  = 4;
  localparam int IW = $clog2(N);

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  btn;
  logic          ready;
  logic          ovf_clr;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic [1:0]    evt_type;
  logic          busy;
  logic          overflow;

  int n_vec;
  int n_err;

  // Reference model state: press age in cycles since the edge was sampled.
  logic          m_track;
  int            m_sel;
  int            m_age;
  logic [N-1:0]  m_prev;
  logic          m_valid;
  int            m_id;
  logic [1:0]    m_type;
  logic          m_ovf;

  btn_event_ctrl #(
    .N_BTN         (N),
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn       (btn),
    .i_evt_ready (ready),
    .i_ovf_clr   (ovf_clr),
    .o_evt_valid (evt_valid),
    .o_evt_id    (evt_id),
    .o_evt_type  (evt_type),
    .o_busy      (busy),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    check_eq("valid", {31'd0, evt_valid}, {31'd0, m_valid});
    check_eq("id", {29'd0, evt_id}, m_id);
    check_eq("type", {30'd0, evt_type}, {30'd0, m_type});
    check_eq("busy", {31'd0, busy}, {31'd0, m_track});
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  task automatic model_reset();
    m_track = 1'b0;
    m_sel   = 0;
    m_age   = 0;
    m_prev  = '1;
    m_valid = 1'b0;
    m_id    = 0;
    m_type  = 2'b00;
    m_ovf   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_eval();
    logic [N-1:0] edges;
    logic         emit;
    logic [1:0]   et;
    edges = btn & ~m_prev;
    emit  = 1'b0;
    et    = 2'b00;
    if (!m_track) begin
      if (edges != '0) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (edges[i]) m_sel = i;
        end
        m_track = 1'b1;
        m_age   = 0;
      end
    end else begin
      m_age++;
      if (!btn[m_sel]) begin
        if (m_age <= L) begin
          emit = 1'b1;
          et   = 2'b00;
        end
        m_track = 1'b0;
      end else if (m_age == L) begin
        emit = 1'b1;
        et   = 2'b01;
      end else if (m_age > L && R != 0 && ((m_age - L) % R) == 0) begin
        emit = 1'b1;
        et   = 2'b10;
      end
    end
    if (emit) begin
      if (!m_valid || ready) begin
        m_valid = 1'b1;
        m_id    = m_sel;
        m_type  = et;
      end
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    if (emit && m_valid && !ready && !(m_id == m_sel && m_type == et && 1'b0)) begin
      // Event register was occupied and not drained: the new event was lost.
    end
    m_prev = btn;
  endtask

  task automatic step();
    logic was_valid;
    logic drop;
    was_valid = m_valid;
    drop = 1'b0;
    // Overflow is decided from the pre-update register state.
    begin
      logic         tr;
      int           ag;
      tr = m_track;
      ag = m_age + 1;
      if (tr && was_valid && !ready) begin
        if (!btn[m_sel]) drop = (ag <= L);
        else drop = (ag == L) || (ag > L && R != 0 && ((ag - L) % R) == 0);
      end
    end
    model_eval();
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    btn     = '0;
    ready   = 1'b1;
    ovf_clr = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    do_reset();
    cycles(2);

    // Short press of button 2.
    btn = 5'b00100; cycles(3);
    btn = 5'b00000; cycles(4);

    // Long hold of button 0 with auto-repeat.
    btn = 5'b00001; cycles(20);
    btn = 5'b00000; cycles(6);

    // Simultaneous edges on 1 and 3; button 3 retoggled while 1 is tracked.
    btn = 5'b01010; cycles(1);
    btn = 5'b00010; cycles(2);
    btn = 5'b01010; cycles(2);
    btn = 5'b00000; cycles(4);

    // Consumer stalled: second SHORT is dropped and overflow latches.
    ready = 1'b0;
    btn = 5'b00100; cycles(2);
    btn = 5'b00000; cycles(2);
    btn = 5'b01000; cycles(2);
    btn = 5'b00000; cycles(3);
    ready = 1'b1; cycles(1);
    ovf_clr = 1'b1; cycles(1);
    ovf_clr = 1'b0; cycles(2);

    // Release exactly at the LONG threshold, then one cycle past it.
    btn = 5'b00010; cycles(L);
    btn = 5'b00000; cycles(3);
    btn = 5'b00010; cycles(L + 1);
    btn = 5'b00000; cycles(3);

    // Button 4 held through reset deassertion produces nothing.
    btn = 5'b10000;
    do_reset();
    cycles(12);
    btn = 5'b00000; cycles(4);

    // Reset while a press is being tracked and an event is pending.
    btn = 5'b01000; cycles(2);
    btn = 5'b00000; ready = 1'b0; cycles(1);
    btn = 5'b00001; cycles(4);
    do_reset();
    btn = 5'b00000; ready = 1'b1; cycles(3);

    // Random button activity, consumer stalls and overflow clears.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(9) == 0) btn[i] = ~btn[i];
      end
      ready   = ($urandom_range(3) != 0);
      ovf_clr = ($urandom_range(15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Press-event scheduler between the per-button `debounce` instances and the lighting mode logic. It arbitrates the debounced button levels so only one button is tracked at a time, and times how long that button is held. It classifies each press as SHORT, LONG or REPEAT (auto-repeat while held) and delivers one event at a time over a valid/ready handshake.

## Interface
- `N_BTN`, 5: number of debounced button inputs (2..8).
- `LONG_CYCLES`, 50_000_000: hold cycles before a LONG event (0.5 s at 100 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, 10_000_000: auto-repeat period after LONG; 0 disables repeat.
- `i_clk` input 1: 100 MHz system clock.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_btn` input N_BTN: debounced, already-synchronous button levels (1 = pressed).
- `i_evt_ready` input 1: consumer accepts the event this cycle.
- `i_ovf_clr` input 1: one-cycle pulse that clears `o_overflow`.
- `o_evt_valid` output 1: event pending.
- `o_evt_id` output $clog2(N_BTN): index of the button that produced the event.
- `o_evt_type` output 2: 00 SHORT, 01 LONG, 10 REPEAT; 11 is never driven.
- `o_busy` output 1: a button is being tracked (state ≠ IDLE).
- `o_overflow` output 1: sticky flag; an event was dropped.

## Operation
- `r_btn_q` registers `i_btn` every cycle. It resets to all ones, so a button held through reset is ignored until it is released and pressed again.
- Rising-edge vector is `i_btn & ~r_btn_q`.
- FSM states: IDLE, HELD, REPEAT.
- IDLE:
  - On any rising edge, latch the lowest-index edge as `r_sel`, clear the counter and go to HELD.
  - Edges on other buttons in the same cycle are discarded.
- HELD:
  - If `i_btn[r_sel]` is 0, emit SHORT and go to IDLE.
  - Otherwise, if the counter equals LONG_CYCLES-1, emit LONG, clear the counter and go to REPEAT.
  - Otherwise, increment the counter.
  - Release takes precedence over reaching the LONG threshold in the same cycle.
- REPEAT:
  - If `i_btn[r_sel]` is 0, go to IDLE with no event.
  - Otherwise, if REPEAT_CYCLES ≠ 0 and the counter equals REPEAT_CYCLES-1, emit REPEAT and clear the counter.
  - Otherwise, increment the counter. With REPEAT_CYCLES = 0 the counter is held.
- Other buttons are ignored while state ≠ IDLE. Their edges are lost, not queued.
- Counter width is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1) bits. The counter never wraps, because it is cleared at each threshold.
- Output register:
  - "Emit" loads `o_evt_id`/`o_evt_type` and sets `o_evt_valid` if the register is free or is being accepted this cycle (`o_evt_valid & i_evt_ready`).
  - Otherwise the event is dropped and `o_overflow` is set.
  - `o_evt_valid` clears on `o_evt_valid & i_evt_ready` when there is no simultaneous emit.
  - `o_evt_id` and `o_evt_type` stay stable while `o_evt_valid` is high.
- `o_overflow`: if a set and `i_ovf_clr` occur in the same cycle, set wins.
- Reset values: `o_evt_valid` = 0, `o_evt_id` = 0, `o_evt_type` = 00, `o_overflow` = 0, `o_busy` = 0, state = IDLE, counter = 0, `r_sel` = 0.
- Asserting reset mid-press abandons the press with no event.

## Timing
- Rising edge sampled in cycle t (state IDLE); HELD from t+1.
- SHORT: release sampled in cycle r → `o_evt_valid` high from r+1.
- LONG: `o_evt_valid` high from t+LONG_CYCLES+1 if the button is still held at t+LONG_CYCLES.
- REPEAT: first at t+LONG_CYCLES+REPEAT_CYCLES+1, then every REPEAT_CYCLES cycles.
- Consumer side: accept in cycle a → `o_evt_valid` low at a+1, unless a new emit lands in cycle a.
- `o_busy` is registered: high from t+1 until the cycle after release is sampled.

## Structure
- Package `btn_evt_pkg`:
  - `EVT_SHORT`/`EVT_LONG`/`EVT_REPEAT` 2-bit constants.
  - State enum constants `ST_IDLE`/`ST_HELD`/`ST_REPEAT`.
- Sub-module `press_timer`: the loadable hold counter with threshold compare.
  - Inputs: clear, enable, limit.
  - Output: `hit` (counter == limit-1).
- The top level holds edge detect, priority select, FSM and the output register.

## Test plan
- Bench uses LONG_CYCLES = 8, REPEAT_CYCLES = 4, N_BTN = 5, `i_evt_ready` = 1.
- Press btn 2 for 3 cycles → one event {id=2, SHORT}, valid exactly 1 cycle after release is sampled; no LONG.
- Hold btn 0 for 20 cycles → LONG at t+9, REPEAT at t+13 and t+17, then nothing after release.
- Rising edges on btn 1 and btn 3 in the same cycle → only btn 1 tracked; btn 3 released and pressed during tracking → no event from btn 3.
- Hold `i_evt_ready` = 0, produce two SHORT events → first retained unchanged, second dropped, `o_overflow` = 1. Pulse `i_ovf_clr` → 0.
- Release exactly in the cycle the counter reaches 7 → SHORT, not LONG.
- Hold btn 4 across reset deassertion → no event. Reset during HELD → all outputs return to reset values immediately.
